ifu_imem_port: RTL and testbench

Instruction-memory port between the instruction fetch unit and the instruction bus. It accepts one fetch address at a time from the fetch unit and runs a single read transaction on a wait-state-capable memory bus. It returns the instruction word to the fetch unit as a one-cycle `data_already` pulse with `data` held stable. It also supports discarding in-flight fetches on flush and reporting misaligned, bus-error and timeout faults.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_imem_timeout.sv | 40 ++++
 rtl/ifu_imem_port.sv | 147 ++++++++++++++
 tb/tb_ifu_imem_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit memory port.
package ifu_pkg;

  localparam int unsigned XLEN = 32;

  // Word returned to the fetch unit alongside a fault indication.
  localparam logic [XLEN-1:0] IMEM_FAULT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } imem_state_t;

  // Instruction fetches must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_imem_timeout.sv
// Watchdog counter for an outstanding bus read: cleared on entry to a
// waiting state, counts while enabled, flags the last permitted cycle.
module ifu_imem_timeout #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires in the LIMIT-th enabled cycle after a clear.
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ifu_imem_port.sv
// Instruction-memory port: one fetch at a time onto a wait-state bus,
// result returned as a one-cycle data_already pulse.
// Optional bus watchdog enabled by defining IFU_IMEM_TIMEOUT_EN.
module ifu_imem_port
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            flush,
  output logic [XLEN-1:0] data,
  output logic            data_already,
  output logic            fault,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  input  logic            mem_err
);

  // Counter must be able to represent the timeout limit.
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  imem_state_t     state_q, state_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            fault_q, fault_d;

  logic accept;
  logic bus_done;
  logic tmo_expired;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign bus_done  = mem_ack || mem_err;

`ifdef IFU_IMEM_TIMEOUT_EN
  logic tmo_clr, tmo_en;

  // Restart on every transition into WAIT or DRAIN, so DRAIN gets a fresh budget.
  assign tmo_clr = ((state_d == WAIT) || (state_d == DRAIN)) && (state_d != state_q);
  assign tmo_en  = (state_q == WAIT) || (state_q == DRAIN);

  ifu_imem_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Next-state and registered-output logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    data_d     = data_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (is_misaligned(req_addr)) begin
            state_d = RESP;
            data_d  = IMEM_FAULT_WORD;
            fault_d = 1'b1;
          end else begin
            state_d    = WAIT;
            mem_addr_d = req_addr;
            mem_rd_d   = 1'b1;
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          if (bus_done) begin
            state_d  = IDLE;
            mem_rd_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_err) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          data_d   = IMEM_FAULT_WORD;
          fault_d  = 1'b1;
        end else if (mem_ack) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          data_d   = mem_rdata;
          fault_d  = 1'b0;
        end else if (tmo_expired) begin
          state_d  = RESP;
          mem_rd_d = 1'b0;
          data_d   = IMEM_FAULT_WORD;
          fault_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (bus_done || tmo_expired) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      data_q     <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      data_q     <= data_d;
      fault_q    <= fault_d;
    end
  end

  assign data_already = (state_q == RESP);
  assign data         = data_q;
  assign fault        = fault_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;

endmodule

// File: tb/tb_ifu_imem_port.sv
// Self-checking bench for ifu_imem_port (timeout cases only when
// IFU_IMEM_TIMEOUT_EN is defined).
module tb_ifu_imem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic        flush;
  logic [31:0] data;
  logic        data_already;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_err;

  ifu_imem_port #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_addr     (req_addr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .flush        (flush),
    .data         (data),
    .data_already (data_already),
    .fault        (fault),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference view of the values the port should be holding.
  logic [31:0] last_addr  = '0;
  logic [31:0] last_data  = '0;
  logic        last_fault = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;      // wait states before ack/err
    bit          ack;
    bit          err;
    int          flush_cyc;  // cycle after accept carrying flush, 0 = none
    int          exp_rd;     // cycles with mem_rd high
    int          exp_pulses;
    logic [31:0] exp_data;
    bit          exp_fault;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Behavioural outcome of one fetch, from the port's rules.
  function automatic vec_t predict(input vec_t v);
    vec_t r = v;
    bit mis = v.addr[1:0] != 2'b00;
    bit dropped = !mis && v.flush_cyc >= 1 && v.flush_cyc <= v.delay + 1;
    r.exp_rd     = mis ? 0 : v.delay + 1;
    r.exp_pulses = dropped ? 0 : 1;
    r.exp_fault  = mis || v.err;
    r.exp_data   = r.exp_fault ? 32'h0 : v.rdata;
    return r;
  endfunction

  // Issue one fetch from an idle port (called at a negedge) and observe it.
  task automatic run_txn(input vec_t v, input string name);
    bit          mis = v.addr[1:0] != 2'b00;
    int          rd_cnt = 0, pulses = 0, pulse_cyc = -1, ready_cyc = -1;
    int          exp_cyc;
    logic [31:0] got_data = '0;
    logic        got_fault = 1'b0;
    logic [31:0] seen_addr = '0;
    exp_cyc   = mis ? 1 : v.delay + 2;
    req_addr  = v.addr;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    for (int j = 1; j <= v.delay + 3; j++) begin
      if (mem_rd) begin
        rd_cnt++;
        seen_addr = mem_addr;
      end
      if (data_already) begin
        pulses++;
        if (pulse_cyc < 0) pulse_cyc = j;
        got_data  = data;
        got_fault = fault;
      end
      if (req_ready && ready_cyc < 0) ready_cyc = j;
      mem_ack   = !mis && v.ack && (j == v.delay + 1);
      mem_err   = !mis && v.err && (j == v.delay + 1);
      mem_rdata = (j == v.delay + 1) ? v.rdata : $urandom;
      flush     = (j == v.flush_cyc);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_err = 1'b0;
    flush   = 1'b0;
    check({name, "_rd_cycles"}, rd_cnt, v.exp_rd);
    check({name, "_pulses"}, pulses, v.exp_pulses);
    check({name, "_ready_cycle"}, ready_cyc, exp_cyc);
    if (!mis) begin
      check({name, "_mem_addr"}, seen_addr, v.addr);
      last_addr = v.addr;
    end
    if (v.exp_pulses == 1) begin
      check({name, "_pulse_cycle"}, pulse_cyc, exp_cyc);
      check({name, "_data"}, got_data, v.exp_data);
      check({name, "_fault"}, got_fault, v.exp_fault);
      last_data  = v.exp_data;
      last_fault = v.exp_fault;
    end
    check({name, "_idle_state"}, {req_ready, data_already, mem_rd}, 3'b100);
    check({name, "_hold_data"}, data, last_data);
    check({name, "_hold_fault"}, fault, last_fault);
    check({name, "_hold_addr"}, mem_addr, last_addr);
  endtask

`ifdef IFU_IMEM_TIMEOUT_EN
  // Fetch with no bus response; the watchdog must end it.
  task automatic timeout_run(input int flush_cyc, input int exp_rd, input int exp_pulses,
                             input string name);
    int rd_cnt = 0, pulses = 0;
    logic got_fault = 1'b0;
    req_addr  = 32'h0000_0800;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      if (mem_rd) rd_cnt++;
      if (data_already) begin
        pulses++;
        got_fault = fault;
      end
      flush = (j == flush_cyc);
      @(negedge clk);
    end
    flush = 1'b0;
    check({name, "_rd_cycles"}, rd_cnt, exp_rd);
    check({name, "_pulses"}, pulses, exp_pulses);
    if (exp_pulses == 1) begin
      check({name, "_fault"}, got_fault, 1'b1);
      check({name, "_data"}, data, 32'h0);
      last_data  = 32'h0;
      last_fault = 1'b1;
    end
    last_addr = 32'h0000_0800;
    check({name, "_idle"}, {req_ready, mem_rd}, 2'b10);
  endtask
`endif

  vec_t vecs[10];

  initial begin
    reset     = 1'b1;
    req_addr  = '0;
    req_valid = 1'b0;
    flush     = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;

    // addr, rdata, delay, ack, err, flush_cyc, exp_rd, exp_pulses, exp_data, exp_fault
    vecs[0] = '{32'h0000_0100, 32'h0050_0093, 0, 1, 0, 0, 1, 1, 32'h0050_0093, 0};
    vecs[1] = '{32'h0000_2000, 32'hDEAD_BEEF, 3, 1, 0, 0, 4, 1, 32'hDEAD_BEEF, 0};
    vecs[2] = '{32'h0000_0102, 32'h1234_5678, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 1};
    vecs[3] = '{32'h0000_0203, 32'h1234_5678, 1, 1, 0, 0, 0, 1, 32'h0000_0000, 1};
    vecs[4] = '{32'h0000_0040, 32'hCAFE_F00D, 1, 1, 1, 0, 2, 1, 32'h0000_0000, 1};
    vecs[5] = '{32'h0000_0044, 32'hCAFE_F00D, 0, 0, 1, 0, 1, 1, 32'h0000_0000, 1};
    vecs[6] = '{32'h0000_3000, 32'hAAAA_5555, 3, 1, 0, 2, 4, 0, 32'h0000_0000, 0};
    vecs[7] = '{32'h0000_3004, 32'h5555_AAAA, 1, 1, 0, 2, 2, 0, 32'h0000_0000, 0};
    vecs[8] = '{32'h0000_3008, 32'h0BAD_CAFE, 0, 1, 0, 2, 1, 1, 32'h0BAD_CAFE, 0};
    vecs[9] = '{32'h0000_300C, 32'h7777_7777, 0, 1, 0, 1, 1, 0, 32'h0000_0000, 0};

    // Reset state
    @(negedge clk);
    check("reset_data", data, 32'h0);
    check("reset_outputs", {data_already, fault, mem_rd}, 3'b000);
    check("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 1'b1);

    // Table-driven fetches
    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second request accepted in RESP
    req_addr = 32'h0000_0400; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_rd1", {mem_rd, req_ready}, 2'b10);
    check("b2b_addr1", mem_addr, 32'h0000_0400);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_ack = 1'b0;
    check("b2b_pulse1", {data_already, req_ready, mem_rd}, 3'b110);
    check("b2b_data1", data, 32'h1111_1111);
    req_addr = 32'h0000_0404; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_rd2", {mem_rd, data_already}, 2'b10);
    check("b2b_addr2", mem_addr, 32'h0000_0404);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    check("b2b_pulse2", {data_already, fault}, 2'b10);
    check("b2b_data2", data, 32'h2222_2222);
    @(negedge clk);
    check("b2b_idle", {req_ready, data_already, mem_rd}, 3'b100);
    last_addr = 32'h0000_0404; last_data = 32'h2222_2222; last_fault = 1'b0;

    // Reset during WAIT, then a late ack that must be ignored
    req_addr = 32'h0000_0300; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_rd", mem_rd, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outputs", {mem_rd, data_already, fault}, 3'b000);
    check("rst_mid_data", data, 32'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_ignored", {data_already, mem_rd, req_ready}, 3'b001);
    check("late_ack_data", data, 32'h0);
    last_addr = '0; last_data = '0; last_fault = 1'b0;

`ifdef IFU_IMEM_TIMEOUT_EN
    timeout_run(0, 4, 1, "tmo_wait");
    timeout_run(2, 6, 0, "tmo_drain");
`endif

    // Randomized fetches against the reference rules
    for (int k = 0; k < 60; k++) begin
      vec_t v;
      v.addr  = $urandom;
      if ($urandom_range(0, 5) != 0) v.addr[1:0] = 2'b00;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 5);
      v.err   = ($urandom_range(0, 3) == 0);
      v.ack   = !v.err || ($urandom_range(0, 1) == 1);
      v.flush_cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, v.delay + 2) : 0;
      v = predict(v);
      run_txn(v, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
